vscale_mem_arbiter: RTL and testbench
=====================================

# vscale_mem_arbiter

Arbitrates the core's instruction-fetch port and data port onto one shared single-outstanding memory bus. It sits between the vscale pipeline (IF and DX/WB memory interfaces) and the external memory, and generates the `imem_wait`/`dmem_wait` and `imem_badmem_e`/`dmem_badmem_e` signals the pipeline control consumes. It also detects misaligned accesses and bus timeouts, and reports both as bad-memory errors.

## Interface
- `TIMEOUT`, 64: maximum cycles from `bus_req` assertion to completion before an error is forced; must be ≥ 2.
- `CNT_W`, `$clog2(TIMEOUT+1)`: timeout counter width (derived).
- `clk` in 1: clock; all state on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `imem_req` in 1: fetch request; `imem_addr` in 32; `imem_rdata` out 32; `imem_wait` out 1; `imem_badmem_e` out 1.
- `dmem_req` in 1: data request; `dmem_wen` in 1; `dmem_size` in 3 (funct3 encoding); `dmem_addr` in 32; `dmem_wdata` in 32.
- `dmem_rdata` out 32; `dmem_wait` out 1; `dmem_badmem_e` out 1.
- `bus_req` out 1: request valid; `bus_wen` out 1; `bus_size` out 3; `bus_addr` out 32; `bus_wdata` out 32.
- `bus_gnt` in 1: request accepted when sampled with `bus_req`.
- `bus_rvalid` in 1: response; `bus_rdata` in 32; `bus_err` in 1.

## Operation
- **States:** IDLE, ADDR (`bus_req`=1, awaiting `bus_gnt`), DATA (awaiting `bus_rvalid`), ERR (one-cycle local error response), DRAIN (discarding a response after timeout). A 1-bit `owner` register (I/D) is latched on leaving IDLE.
- **IDLE:** arbitrate among asserted requests.
  - Misaligned winner → ERR. Misaligned means size[1:0]=01 with addr[0]≠0, or size[1:0]=10 with addr[1:0]≠0. imem is always word-sized.
  - Otherwise → ADDR. Latch addr, wen, size and wdata into bus registers. imem uses wen=0, size=3'b010.
- **ADDR:** `bus_req` held with stable fields. `bus_gnt`=1 → DATA.
- **DATA:** `bus_rvalid`=1 → completion. Result is `bus_rdata` to owner rdata, and `bus_err` to owner badmem_e. Then → IDLE.
- **ERR:** completion with badmem_e=1, rdata=0; → IDLE.
- **Timeout counter:**
  - Cleared on entry to ADDR; increments each cycle in ADDR and DATA.
  - Fires when counter == TIMEOUT-1 and the cycle is not already a completion. Firing is a completion with badmem_e=1.
  - From ADDR: `bus_req` drops (the bus permits withdrawal before grant) → IDLE.
  - From DATA: → DRAIN.
- **DRAIN:** no new arbitration. `bus_rvalid` is consumed silently → IDLE.
- **Requester handshake:**
  - `x_wait` = `x_req` && !(owner==x && completion this cycle).
  - Requester holds request fields stable while `x_wait`=1.
  - Completion is a single cycle; rdata and badmem_e are valid only in that cycle and zero otherwise.
- **Requester drop:** if the owner drops `x_req` mid-transaction, the transaction runs to completion and the result is discarded. This covers imem kill on redirect.
- **Simultaneous events:** `bus_rvalid` in the same cycle as a timeout counts as normal completion; the timeout is ignored.

## Timing
- **Reset values:** state=IDLE; `bus_req`=0; `bus_addr`, `bus_wdata`, `bus_size`, `bus_wen`=0; owner=I; counter=0; last-served=I. Requester outputs are then combinationally `x_wait`=`x_req`, rdata=0, badmem_e=0.
- **Reset mid-transaction:** immediate return to IDLE, and any in-flight bus response is not tracked. The bus slave shares `reset_n`.
- **Minimum latency:** request at cycle 0 (IDLE) → `bus_req` at cycle 1 → `bus_gnt` at cycle 1 → `bus_rvalid` at cycle 2 → wait low at cycle 2. Next arbitration happens at cycle 3.
- **Misaligned access:** request at cycle 0 → ERR at cycle 1, with wait low and badmem_e high in cycle 1.
- **Combinational paths:** rdata, badmem_e and wait depend combinationally on `bus_rvalid`, `bus_rdata` and `bus_err`. All bus outputs are registered.

## Configuration
- `VSCALE_ARB_RR_EN` defined: round-robin arbitration. When both request, the requester not served last wins. The last-served register updates on every completion.
- `VSCALE_ARB_RR_EN` undefined: fixed priority, dmem always wins over imem. The last-served register is not implemented.

## Test plan
- **imem word fetch:** imem_req, addr=0x100, gnt at once, rvalid next cycle with rdata=0x00000013 → imem_rdata=0x13 with imem_wait low in cycle 2; `bus_size`=3'b010, `bus_wen`=0.
- **Contention:** both request at cycle 0, repeated twice.
  - Fixed priority: dmem, dmem.
  - With `VSCALE_ARB_RR_EN`: dmem first, then imem (reset last-served=I), observed via `bus_addr` order.
- **Misaligned store:** dmem_size=3'b010, addr=0x202 → no `bus_req`; dmem_badmem_e=1 and dmem_wait=0 at cycle 1.
- **Timeout with drain:** TIMEOUT=4, gnt at cycle 1, rvalid held off → dmem_badmem_e at cycle 4. A new imem_req is not granted until a late rvalid at cycle 9; `bus_req` for imem appears at cycle 11.
- **Bus error:** `bus_err`=1 with rvalid → imem_badmem_e=1 for exactly one cycle.
- **Reset mid-transaction:** `reset_n` low during DATA → `bus_req`=0 and waits follow req asynchronously; the first request after release is re-arbitrated from IDLE.

Source files
------------

// File: rtl/vscale_mem_arbiter.sv
// vscale_mem_arbiter: shares one single-outstanding memory bus between imem and dmem, with misalign and timeout errors.
// Define VSCALE_ARB_RR_EN for round-robin arbitration; otherwise dmem has fixed priority.
module vscale_mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_wait,
  output logic        imem_badmem_e,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e,
  output logic        bus_req,
  output logic        bus_wen,
  output logic [2:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, DRAIN} state_t;
  state_t state, state_nx;
  logic owner, owner_nx, pick_d, mis, load, resp, tmo, comp, res_err, i_done, d_done;
  logic [31:0] res_rdata;
  logic [CNT_W-1:0] cnt;
`ifdef VSCALE_ARB_RR_EN
  logic last_d;
  assign pick_d = dmem_req && (!imem_req || !last_d);
`else
  assign pick_d = dmem_req;
`endif
  assign mis = pick_d ? (dmem_size[1:0] == 2'b01 && dmem_addr[0]) ||
                        (dmem_size[1:0] == 2'b10 && dmem_addr[1:0] != 2'b00)
                      : imem_addr[1:0] != 2'b00;
  assign resp = state == DATA && bus_rvalid;
  assign tmo = (state == ADDR || state == DATA) && cnt == CNT_W'(TIMEOUT - 1) && !resp;
  assign comp = resp || state == ERR || tmo;
  assign res_err = resp ? bus_err : 1'b1;
  assign res_rdata = resp ? bus_rdata : 32'h0;
  assign i_done = imem_req && !owner && comp;
  assign d_done = dmem_req && owner && comp;
  assign imem_wait = imem_req && !i_done;
  assign dmem_wait = dmem_req && !d_done;
  assign imem_rdata = i_done ? res_rdata : 32'h0;
  assign dmem_rdata = d_done ? res_rdata : 32'h0;
  assign imem_badmem_e = i_done && res_err;
  assign dmem_badmem_e = d_done && res_err;
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    load = 1'b0;
    case (state)
      IDLE: if (imem_req || dmem_req) begin
        owner_nx = pick_d;
        state_nx = mis ? ERR : ADDR;
        load = !mis;
      end
      // a grant coinciding with the timeout still produces a response, which must be drained
      ADDR: state_nx = bus_gnt ? (tmo ? DRAIN : DATA) : (tmo ? IDLE : ADDR);
      DATA: state_nx = bus_rvalid ? IDLE : (tmo ? DRAIN : DATA);
      ERR: state_nx = IDLE;
      DRAIN: state_nx = bus_rvalid ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= 1'b0;
      cnt <= '0;
      bus_req <= 1'b0;
      bus_wen <= 1'b0;
      bus_size <= 3'b000;
      bus_addr <= 32'h0;
      bus_wdata <= 32'h0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      bus_req <= state_nx == ADDR;
      cnt <= load ? '0 : (state == ADDR || state == DATA) ? cnt + 1'b1 : cnt;
      if (load) begin
        bus_addr <= pick_d ? dmem_addr : imem_addr;
        bus_wen <= pick_d && dmem_wen;
        bus_size <= pick_d ? dmem_size : 3'b010;
        bus_wdata <= pick_d ? dmem_wdata : 32'h0;
      end
    end
  end
`ifdef VSCALE_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_d <= 1'b0;
    else if (comp) last_d <= owner;
  end
`endif
endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// tb_vscale_mem_arbiter: directed stimulus with a scoreboard of expected bus issues and requester completions.
module tb_vscale_mem_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic imem_req = 0, imem_wait, imem_badmem_e;
  logic [31:0] imem_addr = 0, imem_rdata;
  logic dmem_req = 0, dmem_wen = 0, dmem_wait, dmem_badmem_e;
  logic [2:0] dmem_size = 0;
  logic [31:0] dmem_addr = 0, dmem_wdata = 0, dmem_rdata;
  logic bus_req, bus_wen, bus_gnt = 0, bus_rvalid = 0, bus_err = 0;
  logic [2:0] bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;
  int cyc = 0, passed = 0, total = 0;
  logic prev_req = 1'b0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0] sz;
    logic w;
    logic e;
    int c;
  } exp_t;
  exp_t bq[$], iq[$], dq[$];

  vscale_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_wait(imem_wait), .imem_badmem_e(imem_badmem_e),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [2:0] sz, input logic w,
                          input logic [31:0] d, input int c);
    exp_t e;
    e.a = a; e.sz = sz; e.w = w; e.d = d; e.e = 1'b0; e.c = c;
    bq.push_back(e);
  endtask

  task automatic push_resp(input logic is_d, input logic [31:0] d, input logic err, input int c);
    exp_t e;
    e.a = 0; e.sz = 0; e.w = 0; e.d = d; e.e = err; e.c = c;
    if (is_d) dq.push_back(e);
    else iq.push_back(e);
  endtask

  // Slave with immediate grant and a one-cycle response; entered in the arbitration cycle.
  task automatic bus_cycle(input logic [31:0] rd, input logic e);
    tick(); bus_gnt = 1;
    tick(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = rd; bus_err = e;
    tick(); bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus_req && !prev_req) begin
        if (bq.size() == 0) chk("bus_unexpected", bus_req, 1'b0);
        else begin
          e = bq.pop_front();
          chk("bus_addr", bus_addr, e.a);
          chk("bus_size", {29'b0, bus_size}, {29'b0, e.sz});
          chk("bus_wen", {31'b0, bus_wen}, {31'b0, e.w});
          if (e.w) chk("bus_wdata", bus_wdata, e.d);
          chk("bus_cycle", cyc, e.c);
        end
      end
      if (imem_req && !imem_wait) begin
        if (iq.size() == 0) chk("imem_unexpected", {31'b0, imem_wait}, 32'd1);
        else begin
          e = iq.pop_front();
          chk("imem_rdata", imem_rdata, e.d);
          chk("imem_badmem", {31'b0, imem_badmem_e}, {31'b0, e.e});
          chk("imem_cycle", cyc, e.c);
        end
      end else begin
        chk("imem_rdata_idle", imem_rdata, 32'h0);
        chk("imem_badmem_idle", {31'b0, imem_badmem_e}, 32'h0);
      end
      if (dmem_req && !dmem_wait) begin
        if (dq.size() == 0) chk("dmem_unexpected", {31'b0, dmem_wait}, 32'd1);
        else begin
          e = dq.pop_front();
          chk("dmem_rdata", dmem_rdata, e.d);
          chk("dmem_badmem", {31'b0, dmem_badmem_e}, {31'b0, e.e});
          chk("dmem_cycle", cyc, e.c);
        end
      end else begin
        chk("dmem_rdata_idle", dmem_rdata, 32'h0);
        chk("dmem_badmem_idle", {31'b0, dmem_badmem_e}, 32'h0);
      end
    end
    prev_req = bus_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the stimulus");
    $fatal(1);
  end

  initial begin
    int t;
    imem_req = 1;
    #3;
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_size", {29'b0, bus_size}, 32'h0);
    chk("rst_bus_wen", {31'b0, bus_wen}, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_imem_wait", {31'b0, imem_wait}, 32'h1);
    chk("rst_dmem_wait", {31'b0, dmem_wait}, 32'h0);
    chk("rst_imem_rdata", imem_rdata, 32'h0);
    chk("rst_imem_badmem", {31'b0, imem_badmem_e}, 32'h0);
    imem_req = 0; dmem_req = 1;
    #1 chk("rst_dmem_wait_follow", {31'b0, dmem_wait}, 32'h1);
    dmem_req = 0;
    tick(); tick();
    reset_n = 1;
    // imem word fetch
    tick(); t = cyc;
    imem_req = 1; imem_addr = 32'h100;
    push_bus(32'h100, 3'b010, 0, 0, t + 1);
    push_resp(0, 32'h13, 0, t + 2);
    bus_cycle(32'h13, 0);
    imem_req = 0;
    // contention, repeated
    tick(); t = cyc;
    imem_req = 1; imem_addr = 32'h104;
    dmem_req = 1; dmem_wen = 1; dmem_size = 3'b010; dmem_addr = 32'h200; dmem_wdata = 32'h11223344;
    push_bus(32'h200, 3'b010, 1, 32'h11223344, t + 1);
    push_resp(1, 32'hA1, 0, t + 2);
    bus_cycle(32'hA1, 0);
    dmem_wen = 0; dmem_addr = 32'h204; dmem_wdata = 0;
`ifdef VSCALE_ARB_RR_EN
    push_bus(32'h104, 3'b010, 0, 0, t + 4);
    push_resp(0, 32'hB2, 0, t + 5);
    bus_cycle(32'hB2, 0);
    imem_req = 0;
    push_bus(32'h204, 3'b010, 0, 0, t + 7);
    push_resp(1, 32'hC3, 0, t + 8);
    bus_cycle(32'hC3, 0);
    dmem_req = 0;
`else
    push_bus(32'h204, 3'b010, 0, 0, t + 4);
    push_resp(1, 32'hB2, 0, t + 5);
    bus_cycle(32'hB2, 0);
    dmem_req = 0;
    push_bus(32'h104, 3'b010, 0, 0, t + 7);
    push_resp(0, 32'hC3, 0, t + 8);
    bus_cycle(32'hC3, 0);
    imem_req = 0;
`endif
    // misaligned word store, misaligned halfword, aligned odd byte
    tick(); t = cyc;
    dmem_req = 1; dmem_wen = 1; dmem_size = 3'b010; dmem_addr = 32'h202; dmem_wdata = 32'hCAFE;
    push_resp(1, 32'h0, 1, t + 1);
    tick(); tick(); t = cyc;
    dmem_wen = 0; dmem_size = 3'b001; dmem_addr = 32'h301;
    push_resp(1, 32'h0, 1, t + 1);
    tick(); tick(); t = cyc;
    dmem_size = 3'b000; dmem_addr = 32'h303;
    push_bus(32'h303, 3'b000, 0, 0, t + 1);
    push_resp(1, 32'h5A, 0, t + 2);
    bus_cycle(32'h5A, 0);
    dmem_req = 0;
    // timeout after grant, then drain of a late response
    tick(); t = cyc;
    dmem_req = 1; dmem_size = 3'b010; dmem_addr = 32'h400;
    push_bus(32'h400, 3'b010, 0, 0, t + 1);
    push_resp(1, 32'h0, 1, t + 4);
    tick(); bus_gnt = 1;
    tick(); bus_gnt = 0;
    tick(); tick();
    tick(); dmem_req = 0; imem_req = 1; imem_addr = 32'h500;
    push_bus(32'h500, 3'b010, 0, 0, t + 11);
    push_resp(0, 32'h77, 0, t + 12);
    tick(); tick(); tick();
    tick(); bus_rvalid = 1; bus_rdata = 32'hBAD;
    tick(); bus_rvalid = 0; bus_rdata = 0;
    tick(); bus_gnt = 1;
    tick(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h77;
    tick(); bus_rvalid = 0; bus_rdata = 0; imem_req = 0;
    // bus error on a fetch
    tick(); t = cyc;
    imem_req = 1; imem_addr = 32'h600;
    push_bus(32'h600, 3'b010, 0, 0, t + 1);
    push_resp(0, 32'h55, 1, t + 2);
    bus_cycle(32'h55, 1);
    imem_req = 0;
    // reset during DATA
    tick(); t = cyc;
    dmem_req = 1; dmem_addr = 32'h700;
    push_bus(32'h700, 3'b010, 0, 0, t + 1);
    tick(); bus_gnt = 1;
    tick(); bus_gnt = 0;
    reset_n = 0;
    #1;
    chk("midrst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("midrst_dmem_wait", {31'b0, dmem_wait}, 32'h1);
    chk("midrst_dmem_rdata", dmem_rdata, 32'h0);
    dmem_req = 0;
    #1 chk("midrst_dmem_wait_drop", {31'b0, dmem_wait}, 32'h0);
    tick(); reset_n = 1;
    tick(); t = cyc;
    dmem_req = 1; dmem_addr = 32'h704;
    push_bus(32'h704, 3'b010, 0, 0, t + 1);
    push_resp(1, 32'h99, 0, t + 2);
    bus_cycle(32'h99, 0);
    dmem_req = 0;
    tick(); tick(); tick();
    chk("bus_queue_left", bq.size(), 32'h0);
    chk("imem_queue_left", iq.size(), 32'h0);
    chk("dmem_queue_left", dq.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
